// File: rtl/rgbstr_sync_gen_pkg.sv
// rgbstr_sync_gen_pkg
// Shared definitions for the RGB stream overlay pipeline:
//   - rgbstr_t : layout of the 26-bit stream word. Fields are listed MSB first,
//                giving B(25) G(24) R(23) XC(22:13) YC(12:3) HS(2) VS(1) Active(0).
//   - DEF_*    : default 640x480@60 timing constants.
//   - CNT_W    : width of the pixel and line counters.
//   - in_window: half-open range test used for the sync pulses.
package rgbstr_sync_gen_pkg;

    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    localparam int DEF_H_VIS  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_V_VIS  = 480;
    localparam int DEF_V_FP   = 10;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;

    typedef struct packed {
        logic             b;
        logic             g;
        logic             r;
        logic [CNT_W-1:0] xc;
        logic [CNT_W-1:0] yc;
        logic             hs;
        logic             vs;
        logic             active;
    } rgbstr_t;

    // True when lo <= c < hi.
    function automatic logic in_window(input logic [CNT_W-1:0] c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/rgbstr_sync_gen_mod_counter.sv
// rgbstr_sync_gen_mod_counter
// Modulo-N counter with an enable and a wrap flag.
// Ports:
//   clk     in   clock
//   reset_n in   synchronous active-low reset, clears the count
//   en      in   advance the count this cycle
//   count   out  current count, 0..MODULUS-1
//   wrap    out  high when enabled at MODULUS-1, i.e. the count returns to 0 on this edge
module rgbstr_sync_gen_mod_counter #(
    parameter int MODULUS = 800,
    parameter int WIDTH   = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    // The wrap flag is combinational so a cascaded counter sees it in the same cycle.
    assign wrap = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/rgbstr_sync_gen.sv
// rgbstr_sync_gen
// Head-of-chain timing generator for the text overlay pipeline. It runs free
// horizontal/vertical counters and emits one registered stream word per pixel
// clock, with RGB preloaded with the background colour inside the visible area.
// Ports:
//   px_clk      in   pixel clock (only clock)
//   reset_n     in   synchronous active-low reset
//   bg_color    in   background colour {B,G,R}
//   RGBStr_o    out  stream word {B,G,R,XC,YC,HS,VS,Active}
//   frame_start out  high while the output word is pixel (0,0)
//   frame_cnt   out  completed-frame count, wraps 255 -> 0
module rgbstr_sync_gen
    import rgbstr_sync_gen_pkg::*;
#(
    parameter int h_vis  = DEF_H_VIS,
    parameter int h_fp   = DEF_H_FP,
    parameter int h_sync = DEF_H_SYNC,
    parameter int h_bp   = DEF_H_BP,
    parameter int v_vis  = DEF_V_VIS,
    parameter int v_fp   = DEF_V_FP,
    parameter int v_sync = DEF_V_SYNC,
    parameter int v_bp   = DEF_V_BP,
    parameter bit hs_pol = 1'b0,
    parameter bit vs_pol = 1'b0
) (
    input  logic        px_clk,
    input  logic        reset_n,
    input  logic [2:0]  bg_color,
    output logic [25:0] RGBStr_o,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    localparam int HT = h_vis + h_fp + h_sync + h_bp;
    localparam int VT = v_vis + v_fp + v_sync + v_bp;

    // The counters are CNT_W bits wide, so a longer line or frame cannot be represented.
    generate
        if (HT > MAX_TOTAL || VT > MAX_TOTAL) begin : g_bad_timing
            $fatal(1, "rgbstr_sync_gen: line or frame total exceeds counter range");
        end
    endgenerate

    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic             h_wrap;
    logic             v_wrap;
    logic             wrap_d;
    rgbstr_t          word_next;
    rgbstr_t          word_q;
    logic             active;

    rgbstr_sync_gen_mod_counter #(
        .MODULUS (HT),
        .WIDTH   (CNT_W)
    ) u_h_counter (
        .clk     (px_clk),
        .reset_n (reset_n),
        .en      (1'b1),
        .count   (hc),
        .wrap    (h_wrap)
    );

    // The line counter only advances when the pixel counter wraps, so its wrap
    // flag marks the last pixel of the last line.
    rgbstr_sync_gen_mod_counter #(
        .MODULUS (VT),
        .WIDTH   (CNT_W)
    ) u_v_counter (
        .clk     (px_clk),
        .reset_n (reset_n),
        .en      (h_wrap),
        .count   (vc),
        .wrap    (v_wrap)
    );

    // Build the word for the current counter position. XC/YC carry raw counts
    // in blanking too, so downstream compare logic needs no special case.
    always_comb begin
        word_next        = '0;
        active           = in_window(hc, 0, h_vis) && in_window(vc, 0, v_vis);
        word_next.active = active;
        word_next.hs     = in_window(hc, h_vis + h_fp, h_vis + h_fp + h_sync) ? hs_pol : ~hs_pol;
        word_next.vs     = in_window(vc, v_vis + v_fp, v_vis + v_fp + v_sync) ? vs_pol : ~vs_pol;
        word_next.xc     = hc;
        word_next.yc     = vc;
        {word_next.b, word_next.g, word_next.r} = active ? bg_color : 3'b000;
    end

    // Output register. wrap_d delays the frame wrap by one cycle so frame_cnt
    // steps on the same edge that registers pixel (0,0) of the new frame,
    // while the (0,0) that follows a reset does not count as a completed frame.
    always_ff @(posedge px_clk) begin
        if (!reset_n) begin
            word_q        <= '0;
            word_q.hs     <= ~hs_pol;
            word_q.vs     <= ~vs_pol;
            frame_start   <= 1'b0;
            frame_cnt     <= '0;
            wrap_d        <= 1'b0;
        end else begin
            word_q        <= word_next;
            frame_start   <= (hc == '0) && (vc == '0);
            wrap_d        <= v_wrap;
            if (wrap_d) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    assign RGBStr_o = word_q;

endmodule

// File: tb/tb_rgbstr_sync_gen.sv
// tb_rgbstr_sync_gen
// Self-checking bench for rgbstr_sync_gen. The DUT runs with a reduced timing
// (20 pixels x 10 lines) so that 256 frames fit in a short run:
//   H: vis 12, fp 2, sync 3, bp 3 -> HS low on XC 14..16, active XC 0..11
//   V: vis 6,  fp 1, sync 2, bp 1 -> VS low on YC 7..8,   active YC 0..5
// A model pushes the expected word for every clock edge into a queue; each
// test task pops and compares it, plus direct checks of the boundary cases.
module tb_rgbstr_sync_gen;

    localparam int HV = 12, HFP = 2, HSY = 3, HBP = 3, HT = 20;
    localparam int VV = 6,  VFP = 1, VSY = 2, VBP = 1, VT = 10;

    typedef struct {
        logic [25:0] word;
        logic        fs;
        logic [7:0]  fc;
    } exp_t;

    logic        px_clk;
    logic        reset_n;
    logic [2:0]  bg_color;
    logic [25:0] rgb_str;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    exp_t exp_q[$];
    int   m_hc;
    int   m_vc;
    int   m_started;
    int   errors;
    int   checks;

    rgbstr_sync_gen #(
        .h_vis  (HV),
        .h_fp   (HFP),
        .h_sync (HSY),
        .h_bp   (HBP),
        .v_vis  (VV),
        .v_fp   (VFP),
        .v_sync (VSY),
        .v_bp   (VBP),
        .hs_pol (1'b0),
        .vs_pol (1'b0)
    ) dut (
        .px_clk      (px_clk),
        .reset_n     (reset_n),
        .bg_color    (bg_color),
        .RGBStr_o    (rgb_str),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    initial px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    // Expected stream word for pixel (x,y) with background bg.
    function automatic logic [25:0] make_word(input int x, input int y, input logic [2:0] bg);
        logic [25:0] w;
        logic        act;
        act       = (x < HV) && (y < VV);
        w         = '0;
        w[0]      = act;
        w[1]      = !((y >= VV + VFP) && (y < VV + VFP + VSY));
        w[2]      = !((x >= HV + HFP) && (x < HV + HFP + HSY));
        w[12:3]   = 10'(y);
        w[22:13]  = 10'(x);
        w[25:23]  = act ? bg : 3'b000;
        return w;
    endfunction

    // Push the expectation for the coming edge, advance the model, clock once
    // and return 1 time unit after the edge.
    task automatic tick();
        exp_t e;
        if (!reset_n) begin
            e.word    = 26'h0000006;
            e.fs      = 1'b0;
            e.fc      = 8'd0;
            m_hc      = 0;
            m_vc      = 0;
            m_started = 0;
        end else begin
            e.word = make_word(m_hc, m_vc, bg_color);
            e.fs   = (m_hc == 0) && (m_vc == 0);
            if (e.fs) m_started++;
            e.fc   = (m_started == 0) ? 8'd0 : 8'(m_started - 1);
            if (m_hc == HT - 1) begin
                m_hc = 0;
                m_vc = (m_vc == VT - 1) ? 0 : m_vc + 1;
            end else begin
                m_hc++;
            end
        end
        exp_q.push_back(e);
        @(posedge px_clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset_n  = 1'b0;
        bg_color = 3'b101;
        repeat (5) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({rgb_str, frame_start, frame_cnt} !== {e.word, e.fs, e.fc}) begin
                errors++;
                $display("[TB] FAIL sb_reset: got %h/%b/%0d expected %h/%b/%0d", rgb_str, frame_start, frame_cnt, e.word, e.fs, e.fc);
            end
            checks++;
            if (rgb_str !== 26'h0000006 || frame_cnt !== 8'd0) begin
                errors++;
                $display("[TB] FAIL reset_word: got %h cnt %0d expected 0000006 cnt 0", rgb_str, frame_cnt);
            end
        end
        reset_n = 1'b1;
        checks++;
        if (rgb_str !== 26'h0000006 || frame_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_cycle1: got %h fs %b expected 0000006 fs 0", rgb_str, frame_start);
        end
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({rgb_str, frame_start, frame_cnt} !== {e.word, e.fs, e.fc}) begin
            errors++;
            $display("[TB] FAIL sb_release: got %h/%b/%0d expected %h/%b/%0d", rgb_str, frame_start, frame_cnt, e.word, e.fs, e.fc);
        end
        checks++;
        if (rgb_str[22:13] !== 10'd0 || rgb_str[12:3] !== 10'd0 || rgb_str[0] !== 1'b1 || frame_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_cycle2: got xc %0d yc %0d act %b fs %b expected 0 0 1 1", rgb_str[22:13], rgb_str[12:3], rgb_str[0], frame_start);
        end
    endtask

    // Rest of line 0 with bg 101: HS low exactly on XC 14..16, RGB only below XC 12.
    task automatic test_hs_window();
        exp_t        e;
        logic        exp_hs;
        logic        exp_act;
        logic [2:0]  exp_rgb;
        for (int x = 1; x < HT; x++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({rgb_str, frame_start, frame_cnt} !== {e.word, e.fs, e.fc}) begin
                errors++;
                $display("[TB] FAIL sb_hs_window: got %h/%b/%0d expected %h/%b/%0d", rgb_str, frame_start, frame_cnt, e.word, e.fs, e.fc);
            end
            exp_hs  = (x >= 14 && x <= 16) ? 1'b0 : 1'b1;
            exp_act = (x <= 11);
            exp_rgb = exp_act ? 3'b101 : 3'b000;
            checks++;
            if (rgb_str[2] !== exp_hs || rgb_str[0] !== exp_act || rgb_str[25:23] !== exp_rgb || rgb_str[22:13] !== 10'(x)) begin
                errors++;
                $display("[TB] FAIL hs_window x=%0d: got hs %b act %b rgb %b xc %0d expected %b %b %b %0d", x, rgb_str[2], rgb_str[0], rgb_str[25:23], rgb_str[22:13], exp_hs, exp_act, exp_rgb, x);
            end
        end
    endtask

    // Runs the rest of frame 0: line wrap (19,3)->(0,4), frame wrap (19,9)->(0,0).
    task automatic test_line_frame_wrap();
        exp_t e;
        int   px;
        int   py;
        bit   done;
        px   = HT - 1;
        py   = 0;
        done = 0;
        for (int n = 0; n < HT * VT + 10 && !done; n++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({rgb_str, frame_start, frame_cnt} !== {e.word, e.fs, e.fc}) begin
                errors++;
                $display("[TB] FAIL sb_wrap: got %h/%b/%0d expected %h/%b/%0d", rgb_str, frame_start, frame_cnt, e.word, e.fs, e.fc);
            end
            if (px == 19 && py == 3) begin
                checks++;
                if (rgb_str[22:13] !== 10'd0 || rgb_str[12:3] !== 10'd4) begin
                    errors++;
                    $display("[TB] FAIL line_wrap: got (%0d,%0d) expected (0,4)", rgb_str[22:13], rgb_str[12:3]);
                end
            end
            if (py == 7 || py == 8) begin
                checks++;
                if (rgb_str[1] !== (e.word[12:3] == 10'd7 || e.word[12:3] == 10'd8 ? 1'b0 : 1'b1)) begin
                    errors++;
                    $display("[TB] FAIL vs_window: got vs %b at yc %0d", rgb_str[1], rgb_str[12:3]);
                end
            end
            if (px == 19 && py == 9) begin
                checks++;
                if (rgb_str[22:13] !== 10'd0 || rgb_str[12:3] !== 10'd0 || frame_start !== 1'b1 || frame_cnt !== 8'd1) begin
                    errors++;
                    $display("[TB] FAIL frame_wrap: got (%0d,%0d) fs %b cnt %0d expected (0,0) 1 1", rgb_str[22:13], rgb_str[12:3], frame_start, frame_cnt);
                end
                done = 1;
            end
            px = int'(e.word[22:13]);
            py = int'(e.word[12:3]);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL wrap_timeout: got no frame wrap expected one within budget");
        end
    endtask

    // bg 001 until word XC=5 of line 1, then 110: XC=6 already carries 110.
    task automatic test_bg_change();
        exp_t e;
        int   x;
        int   y;
        bit   switched;
        bg_color = 3'b001;
        switched = 0;
        for (int n = 0; n < 3 * HT; n++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({rgb_str, frame_start, frame_cnt} !== {e.word, e.fs, e.fc}) begin
                errors++;
                $display("[TB] FAIL sb_bg: got %h/%b/%0d expected %h/%b/%0d", rgb_str, frame_start, frame_cnt, e.word, e.fs, e.fc);
            end
            x = int'(e.word[22:13]);
            y = int'(e.word[12:3]);
            if (y == 1 && x == 5) begin
                bg_color = 3'b110;
                switched = 1;
            end
            if (y == 1 && x == 4) begin
                checks++;
                if (rgb_str[25:23] !== 3'b001) begin
                    errors++;
                    $display("[TB] FAIL bg_old: got %b expected 001", rgb_str[25:23]);
                end
            end
            if (y == 1 && (x == 6 || x == 11)) begin
                checks++;
                if (rgb_str[25:23] !== 3'b110) begin
                    errors++;
                    $display("[TB] FAIL bg_new x=%0d: got %b expected 110", x, rgb_str[25:23]);
                end
            end
            if (y == 1 && x == 12) begin
                checks++;
                if (rgb_str[25:23] !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL bg_blank: got %b expected 000", rgb_str[25:23]);
                end
            end
        end
        checks++;
        if (!switched) begin
            errors++;
            $display("[TB] FAIL bg_timeout: got no word (5,1) expected one");
        end
    endtask

    // One-cycle reset at word (9,3): reset word, then (0,0) with count back to 0.
    task automatic test_reset_mid();
        exp_t e;
        bit   found;
        found = 0;
        for (int n = 0; n < HT * VT + 10 && !found; n++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({rgb_str, frame_start, frame_cnt} !== {e.word, e.fs, e.fc}) begin
                errors++;
                $display("[TB] FAIL sb_mid: got %h/%b/%0d expected %h/%b/%0d", rgb_str, frame_start, frame_cnt, e.word, e.fs, e.fc);
            end
            if (e.word[22:13] == 10'd9 && e.word[12:3] == 10'd3) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL mid_timeout: got no word (9,3) expected one");
        end
        reset_n = 1'b0;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (rgb_str !== 26'h0000006 || frame_start !== 1'b0 || frame_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL mid_reset_word: got %h fs %b cnt %0d expected 0000006 0 0", rgb_str, frame_start, frame_cnt);
        end
        reset_n = 1'b1;
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({rgb_str, frame_start, frame_cnt} !== {e.word, e.fs, e.fc}) begin
            errors++;
            $display("[TB] FAIL sb_mid_release: got %h/%b/%0d expected %h/%b/%0d", rgb_str, frame_start, frame_cnt, e.word, e.fs, e.fc);
        end
        checks++;
        if (rgb_str[22:3] !== 20'd0 || frame_start !== 1'b1 || frame_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL mid_restart: got xy %h fs %b cnt %0d expected 0 1 0", rgb_str[22:3], frame_start, frame_cnt);
        end
    endtask

    // 256 frames from a fresh (0,0): pulses every 200 cycles, count wraps to 0.
    task automatic test_long_run();
        exp_t e;
        int   pulses;
        int   last;
        pulses = 0;
        last   = 0;
        for (int n = 1; n <= 256 * HT * VT + 20 && pulses < 256; n++) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if ({rgb_str, frame_start, frame_cnt} !== {e.word, e.fs, e.fc}) begin
                errors++;
                $display("[TB] FAIL sb_long: got %h/%b/%0d expected %h/%b/%0d", rgb_str, frame_start, frame_cnt, e.word, e.fs, e.fc);
            end
            if (frame_start === 1'b1) begin
                pulses++;
                checks++;
                if (n - last !== 200) begin
                    errors++;
                    $display("[TB] FAIL pulse_spacing: got %0d cycles expected 200", n - last);
                end
                last = n;
                if (pulses == 255) begin
                    checks++;
                    if (frame_cnt !== 8'd255) begin
                        errors++;
                        $display("[TB] FAIL cnt_255: got %0d expected 255", frame_cnt);
                    end
                end
            end
        end
        checks++;
        if (pulses !== 256 || frame_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL cnt_wrap: got %0d pulses cnt %0d expected 256 pulses cnt 0", pulses, frame_cnt);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        m_hc      = 0;
        m_vc      = 0;
        m_started = 0;
        reset_n   = 1'b0;
        bg_color  = 3'b000;
        test_reset();
        test_hs_window();
        test_line_frame_wrap();
        test_bg_change();
        test_reset_mid();
        test_long_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgbstr_sync_gen.md
# rgbstr_sync_gen

Head-of-chain timing generator for the text overlay pipeline. It runs free-running horizontal and vertical pixel counters and emits the 26-bit RGB stream that every downstream overlay stage consumes. Each stream word carries active, VS, HS, YC, XC and RGB, with RGB preloaded with a background colour. It also provides a per-frame pulse and a frame counter so animated overlays can update between frames.

## Interface
- `h_vis`, 640: visible pixels per line.
- `h_fp`, 16: horizontal front porch, in pixels.
- `h_sync`, 96: HS pulse width, in pixels.
- `h_bp`, 48: horizontal back porch, in pixels.
- `v_vis`, 480: visible lines.
- `v_fp`, 10: vertical front porch, in lines.
- `v_sync`, 2: VS pulse width, in lines.
- `v_bp`, 33: vertical back porch, in lines.
- `hs_pol`, 0: HS active level. 0 means active-low.
- `vs_pol`, 0: VS active level. 0 means active-low.

Ports:
- `px_clk`  in  1: pixel clock. This is the only clock.
- `reset_n`  in  1: synchronous, active-low reset.
- `bg_color`  in  3: background colour {B,G,R}, sampled every cycle.
- `RGBStr_o`  out  26: stream word.
  - bit 0: Active
  - bit 1: VS
  - bit 2: HS
  - bits 12:3: YC
  - bits 22:13: XC
  - bit 23: R
  - bit 24: G
  - bit 25: B
- `frame_start`  out  1: one-cycle pulse, high while the current output word is pixel (0,0).
- `frame_cnt`  out  8: count of completed frames. Wraps 255 -> 0.

## Operation
- Internal counters `hc` and `vc` are 10 bits each.
  - Line total `HT = h_vis+h_fp+h_sync+h_bp`. Frame total `VT = v_vis+v_fp+v_sync+v_bp`.
  - `HT` and `VT` must each be ≤ 1024; this is checked at elaboration and is a fatal error if violated.
- Counter update each cycle:
  - `hc` increments.
  - At `hc = HT-1`, `hc` wraps to 0 and `vc` increments.
  - At `vc = VT-1` together with `hc = HT-1`, `vc` wraps to 0 and `frame_cnt` increments.
- Output word, registered from the current `hc`/`vc`:
  - Active = (`hc < h_vis`) && (`vc < v_vis`).
  - HS = `hs_pol` when `h_vis+h_fp ≤ hc < h_vis+h_fp+h_sync`, otherwise `~hs_pol`.
  - VS uses the same rule with the vertical parameters.
  - XC = `hc`, YC = `vc`. Raw counter values are carried in blanking too, so downstream compare logic needs no special case.
  - RGB = `bg_color` when Active, otherwise 3'b000.
- `frame_start` is registered alongside the stream word and is high iff that word has `hc=0, vc=0`.
- No back-pressure: the stream advances every cycle and never stalls.

## Timing
- Latency: `RGBStr_o` and `frame_start` reflect the counter state one cycle earlier.
- Change from `bg_color` to RGB: one cycle.
- Reset, while `reset_n=0` at a clock edge:
  - `hc=vc=0`, `frame_cnt=0`.
  - `RGBStr_o` = Active 0, HS `~hs_pol`, VS `~vs_pol`, XC 0, YC 0, RGB 0.
  - `frame_start=0`.
- First cycle after reset release:
  - Output is still the reset word; counters advance from 0.
  - Second cycle: the output shows (0,0) with Active=1 and `frame_start=1`.
- Reset asserted mid-frame takes effect on the next edge, with no partial-line completion.
- Boundaries with default parameters:
  - HS is asserted in words with XC 656..751.
  - VS is asserted in words with YC 490..491.
  - The last active word is (639,479).
  - Line wrap: word (799,y) is followed by (0,y+1).
  - Frame wrap: word (799,524) is followed by (0,0) with `frame_start=1`.
  - `frame_cnt` increments on the same edge that registers (0,0).

## Structure
- Shared include `rgbstr_defs.vh` holds:
  - the stream field aliases (Active, VS, HS, YC, XC, R, G, B, RGB, VGA) used by every stage;
  - the default 640x480@60 timing constants.
- One sub-module is natural: `mod_counter` (parameterised modulus, enable, wrap output). Instantiate it twice, with the H wrap output driving the V enable.
- Target size: about 150 lines total.

## Test plan
- Reset values: hold `reset_n=0` for 5 cycles → `RGBStr_o`=26'h0000006 (HS=VS=1, all else 0) and `frame_cnt`=0. Release → 2nd cycle after release shows XC=0, YC=0, Active=1, `frame_start`=1.
- HS window: in line 0, HS=0 exactly for words XC=656..751, and Active=0 from XC=640 onward. `bg_color`=3'b101 gives RGB 101 only for XC<640.
- Line and frame wrap: word (799,10) → next (0,11). Word (799,524) → next (0,0) with `frame_start`=1, and `frame_cnt` 0→1. VS=0 only on YC=490,491.
- Background change: switch `bg_color` 3'b001→3'b110 at XC=100 → word XC=101 carries 110. Words within 1 cycle of a blanking boundary carry 000.
- Reset mid-frame: assert `reset_n=0` at word (300,200) for 1 cycle → next word is the reset word, then (0,0) follows. `frame_cnt` returns to 0.
- Long run: 256 frames → `frame_cnt` wraps to 0. Exactly 256 `frame_start` pulses, spaced 420000 cycles apart.
